// File: rtl/fadd_sched_pkg.sv
// Shared types and constants for the FP-add request scheduler.
// Widths, flag positions and canonical NaN patterns live here.
package fadd_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int FLG_TIMEOUT = 4;
  localparam int FLG_NAN     = 3;
  localparam int FLG_OVF     = 2;
  localparam int FLG_UNF     = 1;
  localparam int FLG_ZERO    = 0;

  localparam int EXP_W64  = 11;
  localparam int FRAC_W64 = 52;
  localparam int EXP_W32  = 8;
  localparam int FRAC_W32 = 23;

  // Quiet NaN: sign set, exponent all ones, fraction MSB set.
  localparam logic [63:0] NAN64 =
    {1'b1, {EXP_W64{1'b1}}, 1'b1, {(FRAC_W64-1){1'b0}}};
  localparam logic [31:0] NAN32 =
    {1'b1, {EXP_W32{1'b1}}, 1'b1, {(FRAC_W32-1){1'b0}}};

  function automatic logic [63:0] canon_nan(input int w);
    return (w == 64) ? NAN64 : {32'd0, NAN32};
  endfunction

endpackage

// File: rtl/fadd_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Produces one-hot grant, its index, and an any-request flag.
module fadd_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] grant,
  output logic [2:0]   idx,
  output logic         any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = 3'(j);
      end
    end
  end

endmodule

// File: rtl/fadd_scheduler.sv
// Round-robin scheduler sharing one external FP adder among requesters.
// Optional watchdog: define FADD_SCHEDULER_WATCHDOG_EN.
module fadd_scheduler
  import fadd_sched_pkg::*;
#(
  parameter int FLOAT_WIDTH = 64,
  parameter int NUM_REQ     = 4,
  parameter int ADD_TIMEOUT = 63
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_op_sub,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op2,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [2:0]                     rsp_id,
  output logic [FLOAT_WIDTH-1:0]         rsp_result,
  output logic [4:0]                     rsp_flags,
  output logic                           add_start,
  output logic                           add_op_sub,
  output logic [FLOAT_WIDTH-1:0]         add_op1,
  output logic [FLOAT_WIDTH-1:0]         add_op2,
  input  logic [FLOAT_WIDTH-1:0]         add_out,
  input  logic                           add_nan,
  input  logic                           add_overflow,
  input  logic                           add_underflow,
  input  logic                           add_zero,
  input  logic                           add_done
);

  if (FLOAT_WIDTH != 32 && FLOAT_WIDTH != 64) begin : g_bad_width
    $error("FLOAT_WIDTH must be 32 or 64");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_nreq
    $error("NUM_REQ must be 2..8");
  end
  if (ADD_TIMEOUT < 1) begin : g_bad_tmo
    $error("ADD_TIMEOUT must be positive");
  end

  state_t state, state_d;

  logic [2:0]             rr_ptr;
  logic [2:0]             gnt_id;
  logic [NUM_REQ-1:0]     pick_gnt;
  logic [2:0]             pick_idx;
  logic                   pick_any;
  logic [FLOAT_WIDTH-1:0] sel_op1;
  logic [FLOAT_WIDTH-1:0] sel_op2;
  logic                   sel_sub;
  logic [4:0]             done_flags;
  logic                   timeout;

  fadd_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_op1 = sel_op1 | req_op1[i*FLOAT_WIDTH +: FLOAT_WIDTH];
        sel_op2 = sel_op2 | req_op2[i*FLOAT_WIDTH +: FLOAT_WIDTH];
      end
    end
    sel_sub = |(req_op_sub & pick_gnt);
  end

  always_comb begin
    done_flags           = '0;
    done_flags[FLG_NAN]  = add_nan;
    done_flags[FLG_OVF]  = add_overflow;
    done_flags[FLG_UNF]  = add_underflow;
    done_flags[FLG_ZERO] = add_zero;
  end

`ifdef FADD_SCHEDULER_WATCHDOG_EN
  localparam int CW = $clog2(ADD_TIMEOUT + 1);
  localparam logic [63:0] NAN_FULL = canon_nan(FLOAT_WIDTH);
  localparam logic [FLOAT_WIDTH-1:0] NAN_VAL = NAN_FULL[FLOAT_WIDTH-1:0];

  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires on the ADD_TIMEOUT-th WAIT cycle.
  assign timeout = (state == S_WAIT) &&
                   ((wd_cnt + 1'b1) == CW'(ADD_TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    req_ready = '0;
    add_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = rst_n ? pick_gnt : '0;
        if (pick_any) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        add_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (add_done || timeout) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      gnt_id     <= '0;
      add_op1    <= '0;
      add_op2    <= '0;
      add_op_sub <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (state == S_IDLE && pick_any) begin
        gnt_id     <= pick_idx;
        add_op1    <= sel_op1;
        add_op2    <= sel_op2;
        add_op_sub <= sel_sub;
      end
      if (state == S_WAIT) begin
        if (add_done) begin
          rsp_id     <= gnt_id;
          rsp_result <= add_out;
          rsp_flags  <= done_flags;
        end
`ifdef FADD_SCHEDULER_WATCHDOG_EN
        else if (timeout) begin
          rsp_id                <= gnt_id;
          rsp_result            <= NAN_VAL;
          rsp_flags             <= '0;
          rsp_flags[FLG_TIMEOUT] <= 1'b1;
          rsp_flags[FLG_NAN]     <= 1'b1;
        end
`endif
      end
      if (state == S_RESP && rsp_ready) begin
        rr_ptr <= (gnt_id == 3'(NUM_REQ-1)) ? 3'd0 : gnt_id + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_fadd_scheduler.sv
// Directed bench for fadd_scheduler with a behavioral adder model.
// Watchdog checks follow FADD_SCHEDULER_WATCHDOG_EN.
module tb_fadd_scheduler;

  localparam int FW = 64;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_op_sub = '0;
  logic [NR*FW-1:0] req_op1 = '0;
  logic [NR*FW-1:0] req_op2 = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [2:0]       rsp_id;
  logic [FW-1:0]    rsp_result;
  logic [4:0]       rsp_flags;
  logic             add_start;
  logic             add_op_sub;
  logic [FW-1:0]    add_op1;
  logic [FW-1:0]    add_op2;
  logic [FW-1:0]    add_out = '0;
  logic             add_nan = 1'b0;
  logic             add_overflow = 1'b0;
  logic             add_underflow = 1'b0;
  logic             add_zero = 1'b0;
  logic             add_done = 1'b0;

  fadd_scheduler #(
    .FLOAT_WIDTH (FW),
    .NUM_REQ     (NR),
    .ADD_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op_sub    (req_op_sub),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .add_start     (add_start),
    .add_op_sub    (add_op_sub),
    .add_op1       (add_op1),
    .add_op2       (add_op2),
    .add_out       (add_out),
    .add_nan       (add_nan),
    .add_overflow  (add_overflow),
    .add_underflow (add_underflow),
    .add_zero      (add_zero),
    .add_done      (add_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Adder model
  bit          m_en = 1'b0;
  bit          m_echo = 1'b0;
  bit          m_busy = 1'b0;
  int          m_lat = 1;
  int          m_cnt = 0;
  logic [63:0] m_out = '0;
  logic [63:0] m_cap = '0;
  logic [3:0]  m_flags = '0;
  bit          manual_done = 1'b0;
  logic [63:0] manual_out = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      add_done = manual_done;
      {add_nan, add_overflow, add_underflow, add_zero} = 4'b0;
      if (manual_done) add_out = manual_out;
      if (m_busy) begin
        if (m_cnt == 0) begin
          add_done = 1'b1;
          add_out  = m_echo ? m_cap : m_out;
          {add_nan, add_overflow, add_underflow, add_zero} = m_flags;
          m_busy   = 1'b0;
        end else begin
          m_cnt--;
        end
      end
      if (add_start && m_en) begin
        m_busy = 1'b1;
        m_cnt  = m_lat - 1;
        m_cap  = add_op1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    m_busy      = 1'b0;
    manual_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [63:0] op1_of(input int i);
    return 64'h1111_0000_0000_0000 * 64'(i + 1);
  endfunction

  function automatic logic [63:0] op2_of(input int i);
    return 64'h0000_2222_0000_0000 * 64'(i + 1);
  endfunction

  task automatic load_ops();
    for (int i = 0; i < NR; i++) begin
      req_op1[i*FW +: FW] = op1_of(i);
      req_op2[i*FW +: FW] = op2_of(i);
    end
    req_op_sub = 4'b1010;
  endtask

  initial begin
    int rdy_n, st_n, t_st, t_rsp, n_rsp, multi, bad, spur, seen, off;
    bit drop;
    int exp_ids[5] = '{0, 1, 2, 3, 0};

    // Reset state, with requests pending
    req_valid = 4'b1111;
    repeat (2) tick();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_add_start", add_start, 0);
    check("rst_add_op1", add_op1, 0);
    check("rst_add_op2", add_op2, 0);
    check("rst_add_op_sub", add_op_sub, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single request from requester 2
    load_ops();
    req_op1[2*FW +: FW] = 64'h3FF0_0000_0000_0000;
    req_op2[2*FW +: FW] = 64'h4000_0000_0000_0000;
    req_op_sub[2] = 1'b0;
    m_en = 1; m_echo = 0; m_lat = 5;
    m_out = 64'h4008_0000_0000_0000; m_flags = 4'b0000;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    rdy_n = 0; st_n = 0; t_st = -1; t_rsp = -1; drop = 0;
    for (int k = 0; k < 40 && t_rsp < 0; k++) begin
      #1;
      if (req_ready != 0) begin
        rdy_n++;
        check("single_ready_bit", req_ready, 4'b0100);
        drop = 1;
      end
      if (add_start) begin
        st_n++;
        t_st = k;
        check("single_op1", add_op1, 64'h3FF0_0000_0000_0000);
        check("single_op2", add_op2, 64'h4000_0000_0000_0000);
        check("single_sub", add_op_sub, 0);
      end
      if (rsp_valid) begin
        t_rsp = k;
        check("single_id", rsp_id, 2);
        check("single_result", rsp_result, 64'h4008_0000_0000_0000);
        check("single_flags", rsp_flags, 0);
      end
      tick();
      if (drop) begin
        req_valid = '0;
        drop = 0;
      end
    end
    check("single_ready_pulses", rdy_n, 1);
    check("single_start_pulses", st_n, 1);
    check("single_latency", t_rsp - t_st, 6);

    // All requesters valid continuously from reset
    do_reset();
    load_ops();
    m_en = 1; m_echo = 1; m_lat = 2;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    n_rsp = 0; rdy_n = 0; multi = 0;
    for (int k = 0; k < 200 && n_rsp < 5; k++) begin
      #1;
      if ($countones(req_ready) > 1) multi++;
      if (req_ready != 0) rdy_n++;
      if (rsp_valid) begin
        check("rr_id", rsp_id, exp_ids[n_rsp]);
        check("rr_result", rsp_result, op1_of(exp_ids[n_rsp]));
        n_rsp++;
      end
      tick();
    end
    check("rr_responses", n_rsp, 5);
    check("rr_ready_pulses", rdy_n, 5);
    check("rr_onehot", multi, 0);

    // Response back-pressure, then wrap-around skip
    do_reset();
    m_en = 1; m_echo = 0; m_lat = 3;
    m_out = 64'hC000_1234_5678_9ABC; m_flags = 4'b0101;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 30 && !rsp_valid; k++) begin
      tick();
      #1;
    end
    check("stall_rsp_valid", rsp_valid, 1);
    check("stall_id", rsp_id, 2);
    check("stall_result", rsp_result, 64'hC000_1234_5678_9ABC);
    check("stall_flags", rsp_flags, 5'b00101);
    req_valid = 4'b0011;
    bad = 0; spur = 0;
    repeat (10) begin
      tick();
      #1;
      if (!rsp_valid || rsp_id != 3'd2 || rsp_flags != 5'b00101 ||
          rsp_result != 64'hC000_1234_5678_9ABC) bad++;
      if (req_ready != 0 || add_start) spur++;
    end
    check("stall_stable", bad, 0);
    check("stall_no_grant", spur, 0);
    rsp_ready = 1'b1;
    tick();
    #1;
    check("hs_rsp_valid_low", rsp_valid, 0);
    check("wrap_skip_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (15) tick();
    check("wrap_rsp_id", rsp_id, 0);

    // Reset in the middle of WAIT; late add_done must be ignored
    m_en = 0;
    req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 20 && !add_start; k++) begin
      tick();
      #1;
    end
    check("abort_start_seen", add_start, 1);
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("abort_op1_cleared", add_op1, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_start", add_start, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    manual_out = 64'hDEAD_BEEF_0000_0001;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      #1;
      if (rsp_valid) seen++;
    end
    check("late_done_ignored", seen, 0);
    req_valid = 4'b0011;
    #1;
    check("ptr_cleared_grant", req_ready, 4'b0001);
    req_valid = '0;
    tick();

    // Adder that never completes
    do_reset();
    m_en = 0;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    for (int k = 0; k < 20 && !add_start; k++) begin
      tick();
      #1;
    end
    check("hang_start_seen", add_start, 1);
    req_valid = '0;
`ifdef FADD_SCHEDULER_WATCHDOG_EN
    off = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      #1;
      if (rsp_valid) begin
        off = k;
        break;
      end
    end
    check("wd_offset", off, 9);
    check("wd_result", rsp_result, 64'hFFF8_0000_0000_0000);
    check("wd_flags", rsp_flags, 5'b11000);
    check("wd_id", rsp_id, 0);
    tick();
    // Completion on the timeout cycle takes priority
    m_en = 1; m_echo = 0; m_lat = 8;
    m_out = 64'h4010_0000_0000_0000; m_flags = 4'b0000;
    req_valid = 4'b0010;
    #1;
    for (int k = 0; k < 20 && !add_start; k++) begin
      tick();
      #1;
    end
    req_valid = '0;
    off = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      #1;
      if (rsp_valid) begin
        off = k;
        break;
      end
    end
    check("race_offset", off, 9);
    check("race_result", rsp_result, 64'h4010_0000_0000_0000);
    check("race_flags", rsp_flags, 0);
    check("race_id", rsp_id, 1);
`else
    seen = 0;
    repeat (200) begin
      tick();
      #1;
      if (rsp_valid) seen++;
    end
    check("no_wd_no_rsp", seen, 0);
    check("no_wd_flags", rsp_flags, 0);
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
